// File: rtl/debug_cmd_ctrl.sv
// Debug command sequencer between the UART byte stream and the BIP core:
// program loads, CPU run-until-halt supervision and data-word readback.
module debug_cmd_ctrl #(
    parameter int         ADDR_W    = 11,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] CMD_START = 8'h01,
    parameter logic [7:0] CMD_PM    = 8'h02,
    parameter logic [7:0] CMD_READ  = 8'h04
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_en,
    input  logic              cpu_halt,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PM_A0,
        S_PM_A1,
        S_PM_D0,
        S_PM_D1,
        S_PM_WR,
        S_RUN,
        S_RD_A0,
        S_RD_A1,
        S_RD_WAIT,
        S_RD_LATCH,
        S_TX_LO,
        S_TXW_LO,
        S_TX_HI,
        S_TXW_HI
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_pm_addr;
    logic [DATA_W-1:0] r_pm_wdata;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [7:0]        r_rd_lo;
    logic [7:0]        r_word_hi;
    logic [7:0]        r_tx_data;

    logic              w_pm_we;
    logic              w_cpu_en;
    logic              w_tx_start;
    logic              w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_PM) begin
                        w_next = S_PM_A0;
                    end else if (rx_data == CMD_START) begin
                        w_next = S_RUN;
                    end else if (rx_data == CMD_READ) begin
                        w_next = S_RD_A0;
                    end
                end
            end
            S_PM_A0:    if (rx_done) w_next = S_PM_A1;
            S_PM_A1:    if (rx_done) w_next = S_PM_D0;
            S_PM_D0:    if (rx_done) w_next = S_PM_D1;
            S_PM_D1:    if (rx_done) w_next = S_PM_WR;
            S_PM_WR:    w_next = S_IDLE;
            S_RUN:      if (cpu_halt) w_next = S_IDLE;
            S_RD_A0:    if (rx_done) w_next = S_RD_A1;
            S_RD_A1:    if (rx_done) w_next = S_RD_WAIT;
            S_RD_WAIT:  w_next = S_RD_LATCH;
            S_RD_LATCH: w_next = S_TX_LO;
            // tx_done is not looked at while tx_start is high
            S_TX_LO:    w_next = S_TXW_LO;
            S_TXW_LO:   if (tx_done) w_next = S_TX_HI;
            S_TX_HI:    w_next = S_TXW_HI;
            S_TXW_HI:   if (tx_done) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pm_we    = 1'b0;
        w_cpu_en   = 1'b0;
        w_tx_start = 1'b0;
        w_busy     = (r_state != S_IDLE);
        unique case (r_state)
            S_PM_WR: w_pm_we    = 1'b1;
            S_RUN:   w_cpu_en   = 1'b1;
            S_TX_LO: w_tx_start = 1'b1;
            S_TX_HI: w_tx_start = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pm_addr  <= '0;
            r_pm_wdata <= '0;
            r_dm_addr  <= '0;
            r_rd_lo    <= '0;
            r_word_hi  <= '0;
            r_tx_data  <= '0;
        end else begin
            unique case (r_state)
                S_PM_A0: begin
                    if (rx_done) r_pm_addr[7:0] <= rx_data;
                end
                S_PM_A1: begin
                    if (rx_done) begin
                        r_pm_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
                    end
                end
                S_PM_D0: begin
                    if (rx_done) r_pm_wdata[7:0] <= rx_data;
                end
                S_PM_D1: begin
                    if (rx_done) begin
                        r_pm_wdata[DATA_W-1:8] <= rx_data[DATA_W-9:0];
                    end
                end
                S_RD_A0: begin
                    if (rx_done) r_rd_lo <= rx_data;
                end
                S_RD_A1: begin
                    if (rx_done) begin
                        r_dm_addr <= {rx_data[ADDR_W-9:0], r_rd_lo};
                    end
                end
                S_RD_LATCH: begin
                    // low byte goes straight out, high byte waits its turn
                    r_tx_data <= dm_rdata[7:0];
                    r_word_hi <= dm_rdata[15:8];
                end
                S_TXW_LO: begin
                    if (tx_done) r_tx_data <= r_word_hi;
                end
                default: ;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = w_tx_start;
    assign pm_we    = w_pm_we;
    assign pm_addr  = r_pm_addr;
    assign pm_wdata = r_pm_wdata;
    assign cpu_en   = w_cpu_en;
    assign dm_addr  = r_dm_addr;
    assign busy     = w_busy;

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Bench for debug_cmd_ctrl: directed scenarios plus a randomized command
// stream checked against a transaction-level model.
module tb_debug_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done;
    logic        tx_done_man = 1'b0;
    logic        tx_done_auto = 1'b0;
    logic        auto_tx = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        pm_we;
    logic [10:0] pm_addr;
    logic [15:0] pm_wdata;
    logic        cpu_en;
    logic        cpu_halt = 1'b0;
    logic [10:0] dm_addr;
    logic [15:0] dm_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:2047];

    assign tx_done = auto_tx ? tx_done_auto : tx_done_man;

    debug_cmd_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_done  (tx_done),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .pm_we    (pm_we),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .cpu_en   (cpu_en),
        .cpu_halt (cpu_halt),
        .dm_addr  (dm_addr),
        .dm_rdata (dm_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dm_rdata <= mem[dm_addr];

    // Observation queues, sampled on the falling edge
    longint      cyc = 0;
    logic [26:0] pm_q [$];
    logic [7:0]  tx_q [$];
    longint      tx_cyc [$];
    int          cpu_cycles = 0;
    int          overlap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pm_we) pm_q.push_back({pm_addr, pm_wdata});
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_cyc.push_back(cyc);
        end
        if (cpu_en) cpu_cycles++;
        if (cpu_en && (pm_we || tx_start)) overlap++;
    end

    // Auto UART TX responder: random stale level during tx_start, then a
    // done pulse after a random delay
    bit pend = 0;
    int dly = 0;
    always @(negedge clk) begin
        if (!auto_tx) begin
            pend = 0;
            tx_done_auto = 1'b0;
        end else if (tx_start) begin
            pend = 1;
            dly = $urandom_range(0, 3);
            tx_done_auto = 1'($urandom_range(0, 1));
        end else if (pend) begin
            if (dly == 0) begin
                tx_done_auto = 1'b1;
                pend = 0;
            end else begin
                dly--;
                tx_done_auto = 1'b0;
            end
        end else begin
            tx_done_auto = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            idle_cycle();
        end
        if (!busy) ok = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        checks++;
        if ({tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, dm_addr, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tx=%h ts=%b we=%b pa=%h pd=%h en=%b da=%h busy=%b want all 0",
                     tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, dm_addr, busy);
        end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_pm_write();
        int n0;
        n0 = pm_q.size();
        put(8'h02); put(8'h00); put(8'h00); put(8'h0F); put(8'h18);
        checks++;
        if (pm_we !== 1'b1 || pm_addr !== 11'h000 || pm_wdata !== 16'h180F) begin
            errors++;
            $display("FAIL pm_write_latency: got we=%b addr=%h data=%h want 1 000 180f", pm_we, pm_addr, pm_wdata);
        end
        idle_cycle();
        checks++;
        if (pm_we !== 1'b0 || busy !== 1'b0 || pm_addr !== 11'h000 || pm_wdata !== 16'h180F) begin
            errors++;
            $display("FAIL pm_write_after: got we=%b busy=%b addr=%h data=%h want 0 0 000 180f",
                     pm_we, busy, pm_addr, pm_wdata);
        end
        checks++;
        if (pm_q.size() != n0 + 1) begin
            errors++;
            $display("FAIL pm_write_pulses: got %0d want 1", pm_q.size() - n0);
        end
    endtask

    task automatic test_pm_high_addr();
        int n0;
        bit ok;
        n0 = pm_q.size();
        put(8'h02); put(8'h01); put(8'hFF); put(8'h00); put(8'h08);
        wait_idle(10, ok);
        checks++;
        if (!ok || pm_q.size() != n0 + 1) begin
            errors++;
            $display("FAIL pm_high_pulses: got %0d want 1 (idle=%b)", pm_q.size() - n0, ok);
        end else begin
            checks++;
            if (pm_q[n0] !== {11'h701, 16'h0800}) begin
                errors++;
                $display("FAIL pm_high_write: got %h want %h", pm_q[n0], {11'h701, 16'h0800});
            end
        end
    endtask

    task automatic test_start();
        int c0, p0, t0;
        c0 = cpu_cycles;
        p0 = pm_q.size();
        t0 = tx_q.size();
        cpu_halt = 1'b0;
        put(8'h01);
        checks++;
        if (cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL start_cpu_en: got %b want 1", cpu_en);
        end
        put(8'h02); put(8'h04); put(8'h01); put(8'h00); put(8'h02);
        idle_cycle();
        cpu_halt = 1'b1;
        idle_cycle();
        checks++;
        if (cpu_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_after_halt: got en=%b busy=%b want 0 0", cpu_en, busy);
        end
        cpu_halt = 1'b0;
        checks++;
        if (cpu_cycles - c0 != 7) begin
            errors++;
            $display("FAIL start_run_len: got %0d want 7", cpu_cycles - c0);
        end
        checks++;
        if (pm_q.size() != p0 || tx_q.size() != t0) begin
            errors++;
            $display("FAIL start_dropped_bytes: got pm=%0d tx=%0d want 0 0", pm_q.size() - p0, tx_q.size() - t0);
        end
        c0 = cpu_cycles;
        cpu_halt = 1'b1;
        put(8'h01);
        idle_cycle(); idle_cycle(); idle_cycle();
        cpu_halt = 1'b0;
        checks++;
        if (cpu_cycles - c0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL start_halt_on_entry: got %0d cycles busy=%b want 1 0", cpu_cycles - c0, busy);
        end
    endtask

    task automatic test_read();
        int t0;
        bit ok;
        logic [10:0] a;
        logic [4:0]  jb;
        t0 = tx_q.size();
        tx_done_man = 1'b1;
        put(8'h04); put(8'h00); put(8'h00);
        checks++;
        if (dm_addr !== 11'h000) begin
            errors++;
            $display("FAIL read_dm_addr: got %h want 000", dm_addr);
        end
        wait_idle(50, ok);
        tx_done_man = 1'b0;
        checks++;
        if (!ok || tx_q.size() != t0 + 2) begin
            errors++;
            $display("FAIL read_tx_count: got %0d want 2 (idle=%b)", tx_q.size() - t0, ok);
        end else begin
            checks++;
            if (tx_q[t0] !== 8'h0F || tx_q[t0+1] !== 8'h00) begin
                errors++;
                $display("FAIL read_tx_bytes: got %h %h want 0f 00", tx_q[t0], tx_q[t0+1]);
            end
            checks++;
            if (tx_cyc[t0+1] - tx_cyc[t0] < 2) begin
                errors++;
                $display("FAIL read_tx_gap: got %0d want >=2", tx_cyc[t0+1] - tx_cyc[t0]);
            end
        end
        a = 11'($urandom);
        jb = 5'($urandom);
        t0 = tx_q.size();
        put(8'h04); put(a[7:0]); put({jb, a[10:8]});
        repeat (8) idle_cycle();
        checks++;
        if (tx_q.size() != t0 + 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_wait_lo: got %0d bytes busy=%b want 1 1", tx_q.size() - t0, busy);
        end
        tx_done_man = 1'b1;
        idle_cycle();
        tx_done_man = 1'b0;
        repeat (6) idle_cycle();
        checks++;
        if (tx_q.size() != t0 + 2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_wait_hi: got %0d bytes busy=%b want 2 1", tx_q.size() - t0, busy);
        end
        tx_done_man = 1'b1;
        idle_cycle();
        tx_done_man = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done_busy: got %b want 0", busy);
        end
        checks++;
        if (tx_q.size() != t0 + 2 || tx_q[t0] !== mem[a][7:0] || tx_q[t0+1] !== mem[a][15:8]) begin
            errors++;
            $display("FAIL read_hs_bytes: got %0d bytes want %h %h at addr %h", tx_q.size() - t0,
                     mem[a][7:0], mem[a][15:8], a);
        end
    endtask

    task automatic test_unknown();
        int n0;
        n0 = pm_q.size();
        put(8'h55);
        put(8'h02); put(8'h02); put(8'h00); put(8'h00); put(8'h00);
        idle_cycle();
        checks++;
        if (pm_q.size() != n0 + 1 || pm_q[pm_q.size()-1] !== {11'h002, 16'h0000}) begin
            errors++;
            $display("FAIL unknown_cmd: got %0d writes last=%h want 1 %h", pm_q.size() - n0,
                     pm_q[pm_q.size()-1], {11'h002, 16'h0000});
        end
    endtask

    task automatic test_reset_mid();
        int n0, t0;
        bit ok;
        n0 = pm_q.size();
        put(8'h02); put(8'h03);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, dm_addr, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: got pa=%h pd=%h da=%h busy=%b want 0", pm_addr, pm_wdata, dm_addr, busy);
        end
        idle_cycle();
        reset = 1'b0;
        idle_cycle();
        t0 = tx_q.size();
        tx_done_man = 1'b1;
        put(8'h04); put(8'h05); put(8'h00);
        checks++;
        if (dm_addr !== 11'h005) begin
            errors++;
            $display("FAIL reset_mid_dm_addr: got %h want 005", dm_addr);
        end
        wait_idle(50, ok);
        tx_done_man = 1'b0;
        checks++;
        if (!ok || tx_q.size() != t0 + 2 || tx_q[t0] !== mem[5][7:0] || tx_q[t0+1] !== mem[5][15:8]) begin
            errors++;
            $display("FAIL reset_mid_read: got %0d bytes want %h %h", tx_q.size() - t0, mem[5][7:0], mem[5][15:8]);
        end
        checks++;
        if (pm_q.size() != n0) begin
            errors++;
            $display("FAIL reset_mid_no_we: got %0d writes want 0", pm_q.size() - n0);
        end
    endtask

    task automatic test_random(input int n);
        logic [26:0] exp_pm [$];
        logic [7:0]  exp_tx [$];
        int          exp_cpu;
        int          p0, t0, c0, k, o0;
        logic [10:0] a;
        logic [15:0] d;
        logic [4:0]  jb;
        logic [7:0]  b;
        bit          ok;
        exp_cpu = 0;
        p0 = pm_q.size();
        t0 = tx_q.size();
        c0 = cpu_cycles;
        o0 = overlap;
        auto_tx = 1'b1;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    a = 11'($urandom);
                    d = 16'($urandom);
                    jb = 5'($urandom);
                    put(8'h02);
                    put(a[7:0]);
                    if ($urandom_range(0, 1) == 1) idle_cycle();
                    put({jb, a[10:8]});
                    put(d[7:0]);
                    if ($urandom_range(0, 1) == 1) idle_cycle();
                    put(d[15:8]);
                    exp_pm.push_back({a, d});
                end
                1: begin
                    k = $urandom_range(0, 5);
                    put(8'h01);
                    repeat (k) begin
                        rx_data = 8'($urandom);
                        rx_done = 1'($urandom_range(0, 1));
                        idle_cycle();
                    end
                    rx_done = 1'b0;
                    cpu_halt = 1'b1;
                    idle_cycle();
                    cpu_halt = 1'b0;
                    exp_cpu += k + 1;
                end
                2: begin
                    a = 11'($urandom);
                    jb = 5'($urandom);
                    put(8'h04);
                    put(a[7:0]);
                    put({jb, a[10:8]});
                    exp_tx.push_back(mem[a][7:0]);
                    exp_tx.push_back(mem[a][15:8]);
                end
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h01 || b == 8'h02 || b == 8'h04) b = 8'($urandom);
                    put(b);
                end
            endcase
            wait_idle(100, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL random_timeout: busy=%b after command %0d", busy, i);
            end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        auto_tx = 1'b0;
        checks++;
        if (pm_q.size() - p0 != exp_pm.size()) begin
            errors++;
            $display("FAIL random_pm_count: got %0d want %0d", pm_q.size() - p0, exp_pm.size());
        end else begin
            foreach (exp_pm[j]) begin
                checks++;
                if (pm_q[p0+j] !== exp_pm[j]) begin
                    errors++;
                    $display("FAIL random_pm_%0d: got %h want %h", j, pm_q[p0+j], exp_pm[j]);
                end
            end
        end
        checks++;
        if (tx_q.size() - t0 != exp_tx.size()) begin
            errors++;
            $display("FAIL random_tx_count: got %0d want %0d", tx_q.size() - t0, exp_tx.size());
        end else begin
            foreach (exp_tx[j]) begin
                checks++;
                if (tx_q[t0+j] !== exp_tx[j]) begin
                    errors++;
                    $display("FAIL random_tx_%0d: got %h want %h", j, tx_q[t0+j], exp_tx[j]);
                end
            end
        end
        checks++;
        if (cpu_cycles - c0 != exp_cpu) begin
            errors++;
            $display("FAIL random_cpu_cycles: got %0d want %0d", cpu_cycles - c0, exp_cpu);
        end
        checks++;
        if (overlap != o0) begin
            errors++;
            $display("FAIL random_overlap: got %0d want 0", overlap - o0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h000F;
        test_reset();
        test_pm_write();
        test_pm_high_addr();
        test_start();
        test_read();
        test_unknown();
        test_reset_mid();
        test_random(60);
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL cpu_overlap: got %0d want 0", overlap);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_cmd_ctrl.md
Name: debug_cmd_ctrl

Overview:
Command sequencer between the UART byte interface and the BIP processor core. It parses host command bytes and acts on them:
- loads program memory;
- starts the CPU and supervises it until halt;
- reads a data-memory word and returns it over UART TX.

It sits inside top, between the rx/tx UART blocks and the CPU/memories. It owns the program-memory write port, the CPU enable, and the debug data-memory read port.

Parameters:
ADDR_W, 11, program/data memory address width (bits)
DATA_W, 16, program word and data word width (must be 16: two bytes)
CMD_START, 8'h01, command code: run CPU until halt
CMD_PM, 8'h02, command code: program-memory write
CMD_READ, 8'h04, command code: data-memory read

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_done  in  1  byte-valid qualifier; one byte accepted per rising clk edge with rx_done=1 (may stay high over consecutive bytes)
tx_done  in  1  UART TX finished current byte (pulse or level)
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle request to transmit tx_data
pm_we  out  1  program-memory write strobe
pm_addr  out  ADDR_W  program-memory write address
pm_wdata  out  DATA_W  program-memory write data
cpu_en  out  1  CPU clock-enable / run
cpu_halt  in  1  CPU executed HALT (level)
dm_addr  out  ADDR_W  debug data-memory read address
dm_rdata  in  DATA_W  data-memory read data, synchronous, 1-cycle latency
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE. tx_data, tx_start, pm_we, pm_addr, pm_wdata, cpu_en, dm_addr and busy are all 0. Any partial command is discarded; reset mid-command or mid-run is legal.
- All multi-byte fields are little-endian, LSB byte first. Address MSB byte: only bits [ADDR_W-9:0] are used; upper bits are ignored.
- States: IDLE, PM_A0, PM_A1, PM_D0, PM_D1, PM_WR, RUN, RD_A0, RD_A1, RD_WAIT, RD_LATCH, TX_LO, TXW_LO, TX_HI, TXW_HI.
- IDLE, on an accepted byte:
  - CMD_PM -> PM_A0.
  - CMD_START -> RUN.
  - CMD_READ -> RD_A0.
  - Any other value is ignored; stay in IDLE.
- PM path:
  - PM_A0 -> PM_A1 -> PM_D0 -> PM_D1, each step on an accepted byte, capturing addr lo, addr hi, data lo, data hi.
  - After the data-hi byte -> PM_WR. In PM_WR: pm_we=1 for exactly one cycle with pm_addr and pm_wdata stable, then -> IDLE.
  - pm_addr and pm_wdata hold their values after the write. pm_we is 0 in every other state.
  - Latency: pm_we is high in the cycle after the edge that accepted the 5th byte.
- RUN:
  - cpu_en=1 from the cycle after CMD_START is accepted.
  - When cpu_halt=1 is sampled: cpu_en=0 the next cycle, -> IDLE.
  - If cpu_halt is already 1 on entry, cpu_en is high for exactly one cycle.
  - rx bytes received during RUN are dropped.
- READ path:
  - RD_A0 -> RD_A1 capture the address. After addr hi -> RD_WAIT, with dm_addr driven from that cycle.
  - RD_WAIT (one cycle, memory latency) -> RD_LATCH: dm_rdata is registered.
  - TX_LO: tx_data=word[7:0], tx_start=1 for one cycle -> TXW_LO. Wait for tx_done=1 -> TX_HI.
  - TX_HI: tx_data=word[15:8], tx_start=1 for one cycle -> TXW_HI. Wait for tx_done=1 -> IDLE.
  - tx_done is ignored in the cycle tx_start is asserted, which guards against a stale level.
  - tx_data holds its value until the next tx_start.
  - rx bytes received during the READ TX phase are dropped.
- A byte arriving in the same cycle the FSM returns to IDLE is not accepted. Acceptance starts the cycle after busy falls.
- cpu_en=0 in all states except RUN. A PM write or READ therefore never overlaps CPU execution.

Test Plan:
1. PM write: rx bytes 02,00,00,0F,18 on consecutive cycles with rx_done held high -> one pm_we pulse, pm_addr=0x000, pm_wdata=0x180F, then busy=0.
2. PM write with high address bits: bytes 02,01,FF,00,08 -> pm_addr=0x701 (upper MSB-byte bits dropped), pm_wdata=0x0800, single pm_we pulse.
3. START: byte 01 for one cycle, cpu_halt=0 for 6 cycles then 1 -> cpu_en high exactly from cycle+1 until the cycle after halt is seen, then 0. Bytes injected during RUN cause no pm_we and no tx_start.
4. READ: bytes 04,00,00; memory returns 0x000F -> dm_addr=0. tx_start with tx_data=0x0F; after tx_done, tx_start with tx_data=0x00; busy falls after the second tx_done. With tx_done held high, each tx_start is still exactly one cycle and the two bytes are ≥2 cycles apart.
5. Unknown command: byte 0x55, then 02,02,00,00,00 -> 0x55 ignored. One pm_we with pm_addr=0x002, pm_wdata=0x0000.
6. Reset mid-command: bytes 02,03 then reset pulse, then 04,05,00 -> outputs return to 0 asynchronously, no pm_we ever. The READ executes with dm_addr=0x005.
